// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file with a per-register busy scoreboard.
//   - NRD combinational read ports, each returning data and busy status.
//   - Write port 0 (ALU writeback) and write port 1 (load writeback); port 1
//     wins when both target the same register.
//   - Register 0 reads as zero, is never written and is never marked busy.
//   - Issue of an instruction with a destination marks that register busy;
//     a writeback clears it. Set wins over clear in the same cycle.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports and to report such registers as not busy.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]  r_rf [NREGS];
    logic [NREGS-1:0] r_busy;

    // -------------------------------------------------------------------------
    // Per-register decode of write and issue traffic
    // -------------------------------------------------------------------------
    logic [NREGS-1:0] w_wr0_hit;   // write port 0 targets register r
    logic [NREGS-1:0] w_wr1_hit;   // write port 1 targets register r
    logic [NREGS-1:0] w_busy_set;  // issuing instruction targets register r
    logic [NREGS-1:0] w_busy_clr;  // any writeback targets register r

    // Decode write and issue addresses into one-hot per-register strobes.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_wr0_hit  = '0;
        w_wr1_hit  = '0;
        w_busy_set = '0;
        w_busy_clr = '0;
        // Register 0 is skipped: its strobes stay at zero, so it is never
        // written and never marked busy.
        for (int r = 1; r < NREGS; r++) begin
            w_wr0_hit[r]  = we0 && (waddr0 == AW'(r));
            w_wr1_hit[r]  = we1 && (waddr1 == AW'(r));
            w_busy_set[r] = iss_valid && (iss_addr == AW'(r));
            w_busy_clr[r] = w_wr0_hit[r] || w_wr1_hit[r];
        end
    end

    // -------------------------------------------------------------------------
    // Register array
    // -------------------------------------------------------------------------
    // Update the data array; port 1 overrides port 0 on an address conflict.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this array is built from flops rather than a RAM macro because
        // every entry must read as zero while reset is asserted; a RAM could
        // not be cleared asynchronously in one step.
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_rf[r] <= '0;
            end
        end else begin
            // NOTE: sequential state is always updated with non-blocking
            // assignments so every flop samples pre-edge values.
            r_rf[0] <= '0;
            for (int r = 1; r < NREGS; r++) begin
                if (w_wr1_hit[r]) begin
                    r_rf[r] <= wdata1;
                end else if (w_wr0_hit[r]) begin
                    r_rf[r] <= wdata0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Busy scoreboard
    // -------------------------------------------------------------------------
    // Track in-flight producers; a new issue wins over a same-cycle writeback
    // because the register now waits for the younger producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_busy_set[r]) begin
                    r_busy[r] <= 1'b1;
                end else if (w_busy_clr[r]) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   w_ra;       // this port's address
        logic            w_ra_nz;    // address is not the zero register
        logic [XLEN-1:0] w_rf_data;  // registered data at the address
        logic            w_rf_busy;  // registered busy at the address

        assign w_ra      = raddr[gi*AW +: AW];
        assign w_ra_nz   = (w_ra != '0);
        assign w_rf_data = w_ra_nz ? r_rf[w_ra] : '0;
        assign w_rf_busy = w_ra_nz & r_busy[w_ra];

`ifdef REGFILE_BYPASS_EN
        logic w_byp1;  // write port 1 hits this read address this cycle
        logic w_byp0;  // write port 0 hits this read address this cycle

        // Writes presented during reset are discarded, so they must not be
        // forwarded either; the zero register is never forwarded.
        assign w_byp1 = !rst && we1 && (waddr1 == w_ra) && w_ra_nz;
        assign w_byp0 = !rst && we0 && (waddr0 == w_ra) && w_ra_nz;

        // Forward the youngest write data; port 1 takes priority as it does
        // in the array. A hit means the producer is completing, so not busy.
        always_comb begin
            rdata[gi*XLEN +: XLEN] = w_rf_data;
            rbusy[gi]              = w_rf_busy;
            if (w_byp1) begin
                rdata[gi*XLEN +: XLEN] = wdata1;
                rbusy[gi]              = 1'b0;
            end else if (w_byp0) begin
                rdata[gi*XLEN +: XLEN] = wdata0;
                rbusy[gi]              = 1'b0;
            end
        end
`else
        // Registered-state read only; same-cycle writes appear next cycle.
        always_comb begin
            rdata[gi*XLEN +: XLEN] = w_rf_data;
            rbusy[gi]              = w_rf_busy;
        end
`endif
    end : g_rd

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp (XLEN=32, NREGS=32, NRD=2). Expected values are
// hand-computed; same-cycle read expectations follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;
    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    function automatic logic [31:0] rd(input int p);
        return rdata[p*XLEN +: XLEN];
    endfunction

    initial begin
        logic [31:0] exp_same;
        logic [31:0] exp_same_busy;

        // ---------------- Reset with a write and issue pending ----------------
        rst       = 1'b1;
        we0       = 1'b1;  waddr0 = 5'd5;  wdata0 = 32'hDEADBEEF;
        we1       = 1'b0;  waddr1 = '0;    wdata1 = '0;
        iss_valid = 1'b1;  iss_addr = 5'd6;
        set_raddr(5'd5, 5'd6);
        repeat (3) tick();
        check("rst_rdata5", rd(0), 32'h0);
        check("rst_rbusy6", {31'b0, rbusy[1]}, 32'h0);

        rst = 1'b0; we0 = 1'b0; iss_valid = 1'b0;
        tick();
        check("post_rst_rdata5", rd(0), 32'h0);
        check("post_rst_rbusy5", {31'b0, rbusy[0]}, 32'h0);
        check("post_rst_rbusy6", {31'b0, rbusy[1]}, 32'h0);

        // ---------------- Basic write / read ----------------
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12345678;
        set_raddr(5'd3, 5'd3);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h12345678;
`else
        exp_same = 32'h0;
`endif
        check("wr3_same_cycle", rd(0), exp_same);
        tick();
        we0 = 1'b0;
        #1;
        check("wr3_port0", rd(0), 32'h12345678);
        check("wr3_port1", rd(1), 32'h12345678);
        check("wr3_not_busy", {30'b0, rbusy}, 32'h0);

        // ---------------- Register 0: write and issue ignored ----------------
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_addr = 5'd0;
        set_raddr(5'd0, 5'd0);
        #1;
        check("r0_same_cycle", rd(1), 32'h0);
        tick();
        we0 = 1'b0; iss_valid = 1'b0;
        #1;
        check("r0_rdata", rd(0), 32'h0);
        check("r0_rbusy", {31'b0, rbusy[0]}, 32'h0);

        // ---------------- Dual write conflict ----------------
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555FFFF;
        set_raddr(5'd7, 5'd3);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h5555FFFF;
`else
        exp_same = 32'h0;
`endif
        check("dual_same_cycle", rd(0), exp_same);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check("dual_port1_wins", rd(0), 32'h5555FFFF);
        check("dual_other_reg", rd(1), 32'h12345678);

        // ---------------- Scoreboard set / clear ----------------
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        iss_valid = 1'b0;
        set_raddr(5'd9, 5'd7);
        #1;
        check("sb9_busy", {31'b0, rbusy[0]}, 32'h1);
        check("sb7_not_busy", {31'b0, rbusy[1]}, 32'h0);
        check("sb9_old_data", rd(0), 32'h0);

        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h42;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same      = 32'h42;
        exp_same_busy = 32'h0;
`else
        exp_same      = 32'h0;
        exp_same_busy = 32'h1;
`endif
        check("sb9_same_rdata", rd(0), exp_same);
        check("sb9_same_rbusy", {31'b0, rbusy[0]}, exp_same_busy);
        tick();
        we1 = 1'b0;
        #1;
        check("sb9_cleared", {31'b0, rbusy[0]}, 32'h0);
        check("sb9_rdata", rd(0), 32'h42);

        // ---------------- Issue + write collision ----------------
        iss_valid = 1'b1; iss_addr = 5'd4;
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h99;
        set_raddr(5'd4, 5'd9);
        tick();
        iss_valid = 1'b0; we0 = 1'b0;
        #1;
        check("coll_rdata", rd(0), 32'h99);
        check("coll_rbusy", {31'b0, rbusy[0]}, 32'h1);
        check("coll_other_rdata", rd(1), 32'h42);
        check("coll_other_rbusy", {31'b0, rbusy[1]}, 32'h0);

        // ---------------- Async reset mid-operation ----------------
        for (int r = 1; r < NREGS; r++) begin
            iss_valid = 1'b1; iss_addr = AW'(r);
            tick();
        end
        iss_valid = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            set_raddr(AW'(r), 5'd0);
            #0.1;
            check($sformatf("all_busy_%0d", r), {31'b0, rbusy[0]}, 32'h1);
        end
        check("all_busy_r0", {31'b0, rbusy[1]}, 32'h0);

        // Pulse reset in the low phase, then inspect before the next edge.
        @(negedge clk);
        rst = 1'b1;
        #0.5;
        rst = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            set_raddr(AW'(r), 5'd3);
            #0.1;
            check($sformatf("async_clr_%0d", r), {31'b0, rbusy[0]}, 32'h0);
        end
        check("async_rdata3", rd(1), 32'h0);
        tick();
        set_raddr(5'd4, 5'd9);
        #1;
        check("post_async_rdata4", rd(0), 32'h0);
        check("post_async_rdata9", rd(1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard. It provides NRD combinational read ports and two synchronous write ports: port 0 for the ALU writeback and port 1 for load writeback. Register 0 is hard-wired to zero. It sits in the decode/issue stage, supplying operands and busy status to the issue logic and accepting writebacks from the execute and memory stages.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- AW (localparam), $clog2(NREGS), address width

Ports (clock and reset first):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rdata  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rbusy  out  NRD  busy flag of the register addressed by each read port
- we0  in  1  write enable, port 0 (ALU)
- waddr0  in  AW  write address, port 0
- wdata0  in  XLEN  write data, port 0
- we1  in  1  write enable, port 1 (load)
- waddr1  in  AW  write address, port 1
- wdata1  in  XLEN  write data, port 1
- iss_valid  in  1  an instruction with a destination issues this cycle
- iss_addr  in  AW  destination register of the issuing instruction

## Operation
- Storage: NREGS × XLEN array rf plus an NREGS-bit array busy.
- Register 0:
  - Reads always return 0 with rbusy=0.
  - Writes to address 0 are ignored.
  - iss_valid with iss_addr=0 does not set busy.
- Write, at the rising edge:
  - If we0, rf[waddr0] ← wdata0. If we1, rf[waddr1] ← wdata1.
  - If both are enabled with waddr0==waddr1, port 1 wins.
- Busy update, at the rising edge, evaluated per register r:
  - set = iss_valid & (iss_addr==r)
  - clr = (we0 & waddr0==r) | (we1 & waddr1==r)
  - busy[r] ← set ? 1 : (clr ? 0 : busy[r]). Set wins over clear: a new producer is in flight.
- Read: combinational and independent per port. The registered path gives rdata_i = rf[raddr_i] and rbusy_i = busy[raddr_i]. REGFILE_BYPASS_EN modifies this (see Configuration).
- Writing a register that is not busy is legal and leaves busy at 0.
- The block has no other FSM. Its state is rf plus busy.

## Timing
- Reset, while rst=1: every rf entry = 0 and every busy bit = 0.
  - Consequently rdata = 0 and rbusy = 0 on all ports.
  - Writes and issues in the same cycle as rst are discarded.
  - Asserting rst mid-operation clears all pending busy bits immediately, without waiting for a clock edge.
- Write latency:
  - Without bypass, data written at edge k is visible on rdata after edge k.
  - With bypass, it is visible combinationally in the same cycle that we is high.
- Scoreboard latency: iss_valid at edge k gives rbusy=1 after edge k. The clear follows the same rule as write latency.
- Simultaneous events:
  - Dual write to the same address: port 1 data wins.
  - Issue plus write to the same register: busy=1 after the edge, and rf takes the written data.
  - A read address equal to a write address on any port follows the bypass rules.
- Address wrap: addresses are AW bits. With NREGS a power of two, every address value is valid, so no out-of-range case exists.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding is enabled.
  - For read port i, if we1 & waddr1==raddr_i & raddr_i≠0, rdata_i = wdata1.
  - Otherwise, if we0 & waddr0==raddr_i & raddr_i≠0, rdata_i = wdata0.
  - Otherwise rdata_i = rf[raddr_i].
  - rbusy_i is forced to 0 when a same-cycle write hits raddr_i. A same-cycle issue does not affect rbusy_i combinationally.
- Undefined: reads return registered state only. A same-cycle write is not visible until the next cycle.

## Test plan
- Reset: drive rst=1 with we0=1, waddr0=5, wdata0=0xDEADBEEF. Then release rst and read address 5. Required: rdata=0, rbusy=0.
- Basic write/read: we0, waddr0=3, wdata0=0x12345678, then read ports 0 and 1 at address 3 on the next cycle. Required: both ports return 0x12345678.
  - Writing 0xFFFFFFFF to address 0 must still read 0.
- Dual-write conflict: we0 and we1 both to address 7, with wdata0=0xAAAA0000 and wdata1=0x5555FFFF. Required: next-cycle read of address 7 = 0x5555FFFF.
- Scoreboard: iss_valid with iss_addr=9 gives rbusy=1 on the next cycle. Then we1 to address 9 with data 0x42.
  - Without bypass, rbusy=0 and rdata=0x42 on the following cycle.
  - In the same cycle as the write, the bypass build shows rbusy=0 and rdata=0x42, while the non-bypass build shows rbusy=1 and the old data.
- Issue/write collision: iss_valid and we0 both target address 4 with data 0x99. Required: next cycle rdata=0x99, rbusy=1.
- Async reset mid-operation: set busy on registers 1–31, then pulse rst between clock edges. Required: all rbusy fall to 0 before the next rising edge.
